// File: rtl/seq_divider_pkg.sv
// ----------------------------------------------------------------------------
// seq_divider_pkg
//   Shared definitions for the sequential divider and the ALU around it:
//   ALU opcode for Division, divider FSM state encodings (3-bit) and the
//   default operand width.
// ----------------------------------------------------------------------------
package seq_divider_pkg;

    // ALU opcode whose result (RC[63:0]) is taken straight from div_out
    localparam logic [4:0] ALU_OP_DIVISION = 5'b01111;

    // Default operand width of the divider
    localparam int DIV_WIDTH = 32;

    // Divider FSM state encodings
    typedef logic [2:0] div_state_t;
    localparam div_state_t ST_IDLE = 3'd0;
    localparam div_state_t ST_PREP = 3'd1;
    localparam div_state_t ST_ITER = 3'd2;
    localparam div_state_t ST_FIX  = 3'd3;
    localparam div_state_t ST_DONE = 3'd4;

endpackage

// File: rtl/seq_divider_div_step.sv
// ----------------------------------------------------------------------------
// div_step
//   One combinational radix-2 restoring division step on unsigned magnitudes.
//   Ports:
//     rem_in  [WIDTH-1:0]  partial remainder before the step
//     dq_in   [WIDTH-1:0]  dividend bits still to shift in / quotient bits so far
//     dvs     [WIDTH-1:0]  divisor magnitude (holds 2^(WIDTH-1) unsigned)
//     rem_out [WIDTH-1:0]  partial remainder after the step
//     dq_out  [WIDTH-1:0]  dq shifted left with the new quotient bit in bit 0
// ----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] dq_in,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] dq_out
);

    logic [WIDTH:0] rem_sh;
    logic           ge;

    always_comb begin
        // Shifted remainder is WIDTH+1 bits so the compare never loses the
        // carried-out bit; the subtraction result is always < dvs and so
        // fits in WIDTH bits.
        rem_sh = {rem_in, dq_in[WIDTH-1]};
        ge     = (rem_sh >= {1'b0, dvs});
        dq_out = {dq_in[WIDTH-2:0], ge};
        if (ge) begin
            rem_out = rem_sh[WIDTH-1:0] - dvs;
        end else begin
            rem_out = rem_sh[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle signed WIDTH/WIDTH integer divider (radix-2 restoring on
//   magnitudes, sign corrected at the end). Fixed latency: done is high in
//   the cycle after edge E0+WIDTH+2, where E0 is the accept edge.
//   Ports:
//     clk          in   rising-edge clock
//     clear        in   asynchronous reset, active-low
//     start        in   request, accepted only in IDLE or DONE
//     dividend     in   [WIDTH-1:0] two's-complement dividend
//     divisor      in   [WIDTH-1:0] two's-complement divisor
//     busy         out  high from the accept edge until DONE is entered
//     done         out  one-cycle pulse, div_out valid
//     div_by_zero  out  set with div_out when the divisor was zero
//     div_out      out  [2*WIDTH-1:0] {remainder, quotient}, held until next result
// ----------------------------------------------------------------------------
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 start,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero,
    output logic [2*WIDTH-1:0]   div_out
);

    div_state_t          state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d;          // raw operands captured at accept
    logic [WIDTH-1:0]    b_q, b_d;
    logic [WIDTH-1:0]    dq_q, dq_d;        // dividend magnitude / quotient
    logic [WIDTH-1:0]    rem_q, rem_d;      // partial remainder
    logic [WIDTH-1:0]    dvs_q, dvs_d;      // divisor magnitude
    logic                qsign_q, qsign_d;
    logic                rsign_q, rsign_d;
    logic                zero_q, zero_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0]  div_out_q, div_out_d;
    logic                dbz_q, dbz_d;

    logic [WIDTH-1:0]    step_rem;
    logic [WIDTH-1:0]    step_dq;

    // Two's-complement negate; the magnitude of the most negative value
    // comes out as 2^(WIDTH-1), which is correct read as unsigned.
    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
        return ~v + 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? neg(v) : v;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .dq_in   (dq_q),
        .dvs     (dvs_q),
        .rem_out (step_rem),
        .dq_out  (step_dq)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        dq_d      = dq_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        qsign_d   = qsign_q;
        rsign_d   = rsign_q;
        zero_d    = zero_q;
        cnt_d     = cnt_q;
        div_out_d = div_out_q;
        dbz_d     = dbz_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // Operands are captured only on the accept edge
                if (start) begin
                    a_d     = dividend;
                    b_d     = divisor;
                    state_d = ST_PREP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PREP: begin
                dq_d    = mag(a_q);
                dvs_d   = mag(b_q);
                qsign_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
                rsign_d = a_q[WIDTH-1];
                zero_d  = (b_q == '0);
                rem_d   = '0;
                cnt_d   = '0;
                state_d = ST_ITER;
            end
            ST_ITER: begin
                rem_d = step_rem;
                dq_d  = step_dq;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (zero_q) begin
                    div_out_d = {a_q, {WIDTH{1'b1}}};
                    dbz_d     = 1'b1;
                end else begin
                    div_out_d = {(rsign_q ? neg(rem_q) : rem_q),
                                 (qsign_q ? neg(dq_q)  : dq_q)};
                    dbz_d     = 1'b0;
                end
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            dq_q      <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            qsign_q   <= 1'b0;
            rsign_q   <= 1'b0;
            zero_q    <= 1'b0;
            cnt_q     <= '0;
            div_out_q <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            dq_q      <= dq_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            qsign_q   <= qsign_d;
            rsign_q   <= rsign_d;
            zero_q    <= zero_d;
            cnt_q     <= cnt_d;
            div_out_q <= div_out_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q == ST_PREP) || (state_q == ST_ITER) || (state_q == ST_FIX);
    assign done        = (state_q == ST_DONE);
    assign div_by_zero = dbz_q;
    assign div_out     = div_out_q;

endmodule

// File: tb/tb_seq_divider.sv
// ----------------------------------------------------------------------------
// tb_seq_divider
//   Directed-vector bench for seq_divider with hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_seq_divider;

    logic        clk;
    logic        clear;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [63:0] div_out;

    int total = 0;
    int bad   = 0;

    seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .clear       (clear),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .div_out     (div_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Present operands and start for one accept edge; returns #1 after it.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until done is seen (bounded). If poke > 0, a start with
    // 45/4 is presented so that it is sampled at edge poke+1.
    task automatic wait_done(input int poke, output int lat);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (start && lat == poke + 1) start = 1'b0;
            if (poke > 0 && lat == poke) begin
                dividend = 32'd45;
                divisor  = 32'd4;
                start    = 1'b1;
            end
            if (done) break;
        end
        start = 1'b0;
    endtask

    int lat;
    int done_cnt;

    initial begin
        clear    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dbz",  {63'd0, div_by_zero}, 64'd0);
        chk("rst_out",  div_out, 64'd0);
        repeat (2) @(negedge clk);
        clear = 1'b1;

        // 100 / 7
        start_op(32'd100, 32'd7);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        wait_done(0, lat);
        chk("t1_lat", 64'(lat), 64'd34);
        chk("t1_out", div_out, 64'h00000002_0000000E);
        chk("t1_dbz", {63'd0, div_by_zero}, 64'd0);
        chk("t1_busy_done", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        chk("t1_pulse", {63'd0, done}, 64'd0);
        repeat (3) @(posedge clk); #1;
        chk("t1_hold", div_out, 64'h00000002_0000000E);

        // signed cases
        start_op(32'hFFFFFF9C, 32'd7);
        wait_done(0, lat);
        chk("t2a_out", div_out, 64'hFFFFFFFE_FFFFFFF2);
        start_op(32'd100, 32'hFFFFFFF9);
        wait_done(0, lat);
        chk("t2b_out", div_out, 64'h00000002_FFFFFFF2);

        // most negative dividend
        start_op(32'h80000000, 32'hFFFFFFFF);
        wait_done(0, lat);
        chk("t4a_out", div_out, 64'h00000000_80000000);
        chk("t4a_dbz", {63'd0, div_by_zero}, 64'd0);
        start_op(32'h80000000, 32'd1);
        wait_done(0, lat);
        chk("t4b_out", div_out, 64'h00000000_80000000);

        // start while busy is ignored, then back-to-back from DONE
        start_op(32'd100, 32'd7);
        wait_done(9, lat);
        chk("t5_lat", 64'(lat), 64'd34);
        chk("t5_out", div_out, 64'h00000002_0000000E);
        dividend = 32'd45;
        divisor  = 32'd4;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t5_b2b_busy", {63'd0, busy}, 64'd1);
        wait_done(0, lat);
        chk("t5_b2b_lat", 64'(lat), 64'd34);
        chk("t5_b2b_out", div_out, 64'h00000001_0000000B);

        // divide by zero
        start_op(32'd5, 32'd0);
        wait_done(0, lat);
        chk("t3_lat", 64'(lat), 64'd34);
        chk("t3_out", div_out, 64'h00000005_FFFFFFFF);
        chk("t3_dbz", {63'd0, div_by_zero}, 64'd1);
        repeat (2) @(posedge clk); #1;
        chk("t3_dbz_hold", {63'd0, div_by_zero}, 64'd1);

        // asynchronous reset mid-operation
        start_op(32'd100, 32'd7);
        repeat (14) @(posedge clk);
        #3;
        clear = 1'b0;
        #1;
        chk("t6_busy", {63'd0, busy}, 64'd0);
        chk("t6_done", {63'd0, done}, 64'd0);
        chk("t6_out",  div_out, 64'd0);
        chk("t6_dbz",  {63'd0, div_by_zero}, 64'd0);
        repeat (2) @(negedge clk);
        clear = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        chk("t6_no_done", 64'(done_cnt), 64'd0);
        start_op(32'd9, 32'd3);
        wait_done(0, lat);
        chk("t6_lat", 64'(lat), 64'd34);
        chk("t6_out2", div_out, 64'h00000000_00000003);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
